// File: rtl/mult_seq_16x16.sv
`default_nettype none
// ============================================================================
// Module   : unsigned_mult_8x8
// Purpose  : Purely combinational 8x8 unsigned multiplier. It is shared by the
//            16x16 sequencer and has no internal state.
// Ports    : A [7:0] in  - multiplicand byte
//            X [7:0] in  - multiplier byte
//            C [15:0] out - A * X
// Revision : 1.0 - initial release
// ============================================================================
module unsigned_mult_8x8 (
    input  logic [7:0]  A,
    input  logic [7:0]  X,
    output logic [15:0] C
);
    assign C = {8'd0, A} * {8'd0, X};
endmodule

// ============================================================================
// Module   : mult_seq_16x16
// Purpose  : Computes an exact 16x16 unsigned product by issuing up to four
//            8x8 partial products, one per cycle, through one shared
//            multiplier. The partial products are accumulated into a 32-bit
//            result. When SKIP_ZERO is set, a partial product is not issued
//            if either of its operand bytes is zero.
// Ports    : clk          in   clock, rising edge
//            rst_n        in   synchronous active-low reset
//            in_valid     in   operand pair valid
//            in_ready     out  operand pair accepted (IDLE only)
//            in_a [15:0]  in   multiplicand
//            in_b [15:0]  in   multiplier
//            out_valid    out  out_product valid
//            out_ready    in   downstream accepts the result
//            out_product  out  in_a * in_b (32 bits)
//            busy         out  high whenever the state is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_16x16 #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] r_product;
    logic [3:0]  r_mask;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;

    logic [3:0]  w_nz_mask;
    logic [3:0]  w_load_mask;
    logic [3:0]  w_mask_next;
    logic [1:0]  w_sel;
    logic [7:0]  w_mult_a;
    logic [7:0]  w_mult_x;
    logic [15:0] w_mult_c;
    logic [31:0] w_pp_shifted;
    logic [31:0] w_acc_next;

    // Bit i is set when both bytes of partial product i are nonzero:
    // p0 = a_lo*b_lo, p1 = a_lo*b_hi, p2 = a_hi*b_lo, p3 = a_hi*b_hi.
    assign w_nz_mask[0] = (in_a[7:0]  != 8'd0) && (in_b[7:0]  != 8'd0);
    assign w_nz_mask[1] = (in_a[7:0]  != 8'd0) && (in_b[15:8] != 8'd0);
    assign w_nz_mask[2] = (in_a[15:8] != 8'd0) && (in_b[7:0]  != 8'd0);
    assign w_nz_mask[3] = (in_a[15:8] != 8'd0) && (in_b[15:8] != 8'd0);
    assign w_load_mask  = SKIP_ZERO ? w_nz_mask : 4'hF;

    // Clearing the lowest set bit retires the partial product issued now.
    assign w_mask_next  = r_mask & (r_mask - 4'd1);

    // Select the lowest pending partial product. Multiplier inputs are held
    // at zero outside CALC so that they are never X.
    always_comb begin
        w_sel    = 2'd0;
        w_mult_a = 8'd0;
        w_mult_x = 8'd0;
        if (r_mask[0])      w_sel = 2'd0;
        else if (r_mask[1]) w_sel = 2'd1;
        else if (r_mask[2]) w_sel = 2'd2;
        else                w_sel = 2'd3;
        if (r_state == ST_CALC) begin
            w_mult_a = w_sel[1] ? r_a[15:8] : r_a[7:0];
            w_mult_x = w_sel[0] ? r_b[15:8] : r_b[7:0];
        end
    end

    unsigned_mult_8x8 u_mult (
        .A (w_mult_a),
        .X (w_mult_x),
        .C (w_mult_c)
    );

    // The shift is the sum of the byte positions: 0, 8, 8 or 16.
    always_comb begin
        w_pp_shifted = 32'd0;
        case (w_sel)
            2'd0:    w_pp_shifted = {16'd0, w_mult_c};
            2'd1,
            2'd2:    w_pp_shifted = {8'd0, w_mult_c, 8'd0};
            default: w_pp_shifted = {w_mult_c, 16'd0};
        endcase
    end

    // The sum cannot exceed 0xFFFE0001, so a carry out is never needed.
    assign w_acc_next = r_acc + w_pp_shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_acc       <= 32'd0;
            r_product   <= 32'd0;
            r_mask      <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_acc      <= 32'd0;
                        r_mask     <= w_load_mask;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_load_mask != 4'd0) begin
                            r_state <= ST_CALC;
                        end else begin
                            // No partial product is nonzero, so the product is zero.
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_product   <= 32'd0;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc  <= w_acc_next;
                    r_mask <= w_mask_next;
                    if (w_mask_next == 4'd0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_product   <= w_acc_next;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mask      <= 4'd0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_product = r_product;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_16x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_16x16
// Purpose  : Self-checking bench for mult_seq_16x16. It runs two instances
//            with shared stimulus: one with SKIP_ZERO=1 and one with
//            SKIP_ZERO=0. Each result is checked against plain arithmetic.
//            Latency is checked against a count of nonzero byte pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_16x16;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_ready;

    logic        in_ready_s,  out_valid_s, busy_s;
    logic [31:0] out_product_s;
    logic        in_ready_f,  out_valid_f, busy_f;
    logic [31:0] out_product_f;

    int n_checks;
    int n_fail;

    mult_seq_16x16 #(.SKIP_ZERO(1'b1)) u_dut_skip (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready_s),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid_s),
        .out_ready   (out_ready),
        .out_product (out_product_s),
        .busy        (busy_s)
    );

    mult_seq_16x16 #(.SKIP_ZERO(1'b0)) u_dut_full (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready_f),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid_f),
        .out_ready   (out_ready),
        .out_product (out_product_f),
        .busy        (busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: count the partial products with both bytes nonzero.
    function automatic int model_issues(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] ab [2];
        logic [7:0] bb [2];
        int cnt;
        ab[0] = a[7:0];  ab[1] = a[15:8];
        bb[0] = b[7:0];  bb[1] = b[15:8];
        cnt = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (ab[i] != 8'd0 && bb[j] != 8'd0) cnt++;
        return cnt;
    endfunction

    function automatic logic [31:0] model_product(input logic [15:0] a, input logic [15:0] b);
        return {16'd0, a} * {16'd0, b};
    endfunction

    // Called right after the accept edge, with out_ready high. It watches both
    // instances for the cycle in which out_valid first appears.
    task automatic finish_op(input logic [15:0] a, input logic [15:0] b);
        int          lat_s;
        int          lat_f;
        logic [31:0] p_s;
        logic [31:0] p_f;
        lat_s = -1;
        lat_f = -1;
        p_s = 32'd0;
        p_f = 32'd0;
        check_eq("busy_after_accept", {30'd0, busy_s, busy_f}, 32'd3);
        for (int n = 0; n < 8; n++) begin
            if (lat_s < 0 && out_valid_s) begin
                lat_s = n;
                p_s = out_product_s;
            end
            if (lat_f < 0 && out_valid_f) begin
                lat_f = n;
                p_f = out_product_f;
            end
            step();
        end
        check_eq("latency_skip", lat_s, model_issues(a, b));
        check_eq("product_skip", p_s, model_product(a, b));
        check_eq("latency_full", lat_f, 32'd4);
        check_eq("product_full", p_f, model_product(a, b));
        check_eq("idle_again", {30'd0, in_ready_s, in_ready_f}, 32'd3);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        check_eq("ready_before_accept", {30'd0, in_ready_s, in_ready_f}, 32'd3);
        step();
        in_valid = 1'b0;
        finish_op(a, b);
    endtask

    function automatic logic [7:0] rand_byte();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 2) return 8'h00;
        if (sel == 2) return 8'hFF;
        return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        logic [31:0] held;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 16'd0;
        in_b = 16'd0;
        out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state.
        check_eq("rst_in_ready", {30'd0, in_ready_s, in_ready_f}, 32'd3);
        check_eq("rst_out_valid", {30'd0, out_valid_s, out_valid_f}, 32'd0);
        check_eq("rst_busy", {30'd0, busy_s, busy_f}, 32'd0);
        check_eq("rst_product_skip", out_product_s, 32'd0);
        check_eq("rst_product_full", out_product_f, 32'd0);

        // Directed cases.
        run_op(16'h1234, 16'h5678);
        run_op(16'hFFFF, 16'hFFFF);
        run_op(16'h00FF, 16'h0002);
        run_op(16'h0000, 16'hABCD);
        run_op(16'h0100, 16'h0001);
        run_op(16'h0001, 16'h0100);

        // Backpressure: hold the result while new operands wait.
        out_ready = 1'b0;
        in_a = 16'h1234;
        in_b = 16'h5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check_eq("bp_valid", {30'd0, out_valid_s, out_valid_f}, 32'd3);
        check_eq("bp_product", out_product_s, 32'h06260060);
        held = out_product_s;
        in_a = 16'hBEEF;
        in_b = 16'h0102;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold_valid", {31'd0, out_valid_s}, 32'd1);
            check_eq("bp_hold_product", out_product_s, held);
            check_eq("bp_hold_in_ready", {30'd0, in_ready_s, in_ready_f}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_release_idle", {30'd0, in_ready_s, out_valid_s}, 32'd2);
        step();
        in_valid = 1'b0;
        check_eq("bp_next_accept", {30'd0, in_ready_s, busy_s}, 32'd1);
        finish_op(16'hBEEF, 16'h0102);

        // Reset during the second CALC cycle.
        in_a = 16'h1234;
        in_b = 16'h5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("midrst_busy", {30'd0, busy_s, busy_f}, 32'd0);
        check_eq("midrst_out_valid", {30'd0, out_valid_s, out_valid_f}, 32'd0);
        check_eq("midrst_in_ready", {30'd0, in_ready_s, in_ready_f}, 32'd3);
        check_eq("midrst_product", out_product_s, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("midrst_no_output", {30'd0, out_valid_s, out_valid_f}, 32'd0);
        end
        run_op(16'h0003, 16'h0005);

        // Random operands with frequent zero bytes.
        for (int t = 0; t < 40; t++) begin
            run_op({rand_byte(), rand_byte()}, {rand_byte(), rand_byte()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
